// File: rtl/ihex_encoder.sv
// Streams the program ROM out as ASCII Intel HEX: type-00 data records of up
// to REC_LEN bytes starting at byte address 0, then a single type-01 EOF record.
module ihex_encoder #(
    parameter int REC_LEN    = 16,
    parameter int DUMP_BYTES = 32768
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [15:0] DUMP_W    = 16'(DUMP_BYTES);
    localparam logic [15:0] REC_LEN_W = 16'(REC_LEN);
    localparam logic [7:0]  REC_LEN_B = 8'(REC_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_FETCH, S_WAIT, S_DATA, S_CSUM, S_EOL, S_EOFREC, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [13:0] rom_addr_q, rom_addr_d;

    logic        xfer;
    logic        begin_rec;
    logic [15:0] eff_len, rec_src, rec_base, addr_inc;
    logic [7:0]  rec_n, rec_sum, csum, sel_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Header ":LLAAAA00"; cnt_q still holds the record length while in HDR.
    function automatic logic [7:0] hdr_char(input logic [3:0] idx, input logic [7:0] n,
                                            input logic [15:0] a);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h3A;
            4'd1:    c = hex_char(n[7:4]);
            4'd2:    c = hex_char(n[3:0]);
            4'd3:    c = hex_char(a[15:12]);
            4'd4:    c = hex_char(a[11:8]);
            4'd5:    c = hex_char(a[7:4]);
            4'd6:    c = hex_char(a[3:0]);
            default: c = 8'h30;
        endcase
        return c;
    endfunction

    // ":00000001FF\r\n"
    function automatic logic [7:0] eof_char(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:         c = 8'h3A;
            4'd8:         c = 8'h31;
            4'd9, 4'd10:  c = 8'h46;
            4'd11:        c = 8'h0D;
            4'd12:        c = 8'h0A;
            default:      c = 8'h30;
        endcase
        return c;
    endfunction

    assign xfer = tx_valid_q & tx_ready;

    always_comb begin
        eff_len  = (length > DUMP_W) ? DUMP_W : length;
        rec_src  = (state_q == S_IDLE) ? eff_len : rem_q;
        rec_base = (state_q == S_IDLE) ? 16'h0000 : addr_q;
        rec_n    = (rec_src > REC_LEN_W) ? REC_LEN_B : rec_src[7:0];
        rec_sum  = rec_n + rec_base[15:8] + rec_base[7:0];
        csum     = 8'h00 - sum_q;
        sel_byte = addr_q[0] ? rom_data[15:8] : rom_data[7:0];
        addr_inc = addr_q + 16'd1;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        sum_d      = sum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rom_addr_d = rom_addr_q;
        begin_rec  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    addr_d = 16'h0000;
                    if (eff_len == 16'h0000) begin
                        state_d    = S_EOFREC;
                        idx_d      = 4'd0;
                        tx_data_d  = 8'h3A;
                        tx_valid_d = 1'b1;
                    end else begin
                        begin_rec = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (idx_q == 4'd8) begin
                        state_d    = S_FETCH;
                        tx_valid_d = 1'b0;
                        rom_addr_d = addr_q[14:1];
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = hdr_char(idx_q + 4'd1, cnt_q, addr_q);
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                byte_d     = sel_byte;
                sum_d      = sum_q + sel_byte;
                state_d    = S_DATA;
                idx_d      = 4'd0;
                tx_data_d  = hex_char(sel_byte[7:4]);
                tx_valid_d = 1'b1;
            end
            S_DATA: begin
                if (xfer) begin
                    if (idx_q == 4'd0) begin
                        idx_d     = 4'd1;
                        tx_data_d = hex_char(byte_q[3:0]);
                    end else begin
                        addr_d = addr_inc;
                        cnt_d  = cnt_q - 8'd1;
                        if (cnt_q > 8'd1) begin
                            state_d    = S_FETCH;
                            tx_valid_d = 1'b0;
                            rom_addr_d = addr_inc[14:1];
                        end else begin
                            state_d   = S_CSUM;
                            idx_d     = 4'd0;
                            tx_data_d = hex_char(csum[7:4]);
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (idx_q == 4'd0) begin
                        idx_d     = 4'd1;
                        tx_data_d = hex_char(csum[3:0]);
                    end else begin
                        state_d   = S_EOL;
                        idx_d     = 4'd0;
                        tx_data_d = 8'h0D;
                    end
                end
            end
            S_EOL: begin
                if (xfer) begin
                    if (idx_q == 4'd0) begin
                        idx_d     = 4'd1;
                        tx_data_d = 8'h0A;
                    end else if (rem_q != 16'h0000) begin
                        begin_rec = 1'b1;
                    end else begin
                        state_d   = S_EOFREC;
                        idx_d     = 4'd0;
                        tx_data_d = 8'h3A;
                    end
                end
            end
            S_EOFREC: begin
                if (xfer) begin
                    if (idx_q == 4'd12) begin
                        state_d    = S_FIN;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = eof_char(idx_q + 4'd1);
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Record length is fixed here; the checksum accumulator restarts with LL+AH+AL.
        if (begin_rec) begin
            state_d    = S_HDR;
            idx_d      = 4'd0;
            tx_data_d  = 8'h3A;
            tx_valid_d = 1'b1;
            cnt_d      = rec_n;
            rem_d      = rec_src - {8'h00, rec_n};
            sum_d      = rec_sum;
            addr_d     = rec_base;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            rem_q      <= 16'h0000;
            cnt_q      <= 8'h00;
            addr_q     <= 16'h0000;
            byte_q     <= 8'h00;
            sum_q      <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_addr_q <= 14'h0000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            sum_q      <= sum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_ihex_encoder.sv
// Scoreboard bench for ihex_encoder: stimulus pushes expected characters, a
// negedge monitor pops and compares every transferred character.
module tb_ihex_encoder;

    // Scaled-down ROM window keeps the clamp case short; the clamp logic is the same.
    localparam int DUMP = 2048;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] length;
    logic        busy, done;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    logic [15:0] rom [0:16383];
    byte unsigned exp_q[$];
    byte unsigned rx_q[$];
    int    n_chk = 0, n_fail = 0;
    int    done_cnt = 0;
    int    ready_mode = 1;
    bit    pend = 1'b0, done_prev = 1'b0, addr_watch = 1'b0, addr_moved = 1'b0;
    logic [7:0]  pend_d = 8'h00;
    logic [13:0] addr_ref = 14'h0;
    string ref20;

    always #5 clk = ~clk;

    ihex_encoder #(.REC_LEN(16), .DUMP_BYTES(DUMP)) dut (
        .clk_sys(clk), .reset(reset), .start(start), .length(length),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 9) < 3);
        endcase
    end

    function automatic logic [7:0] romb(input int b);
        case (b)
            0:       return 8'h0C;
            1:       return 8'h94;
            2:       return 8'h34;
            default: return 8'((b * 37) ^ (b >> 5));
        endcase
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_hex(input logic [7:0] v);
        exp_q.push_back(hexc(v[7:4]));
        exp_q.push_back(hexc(v[3:0]));
    endtask

    // Reference Intel HEX formatter for a dump of len bytes from address 0.
    task automatic model_dump(input int len);
        int eff, addr, n;
        logic [7:0] sum, b;
        eff  = (len > DUMP) ? DUMP : len;
        addr = 0;
        while (addr < eff) begin
            n = (eff - addr > 16) ? 16 : eff - addr;
            exp_q.push_back(8'h3A);
            push_hex(8'(n));
            push_hex(8'(addr >> 8));
            push_hex(8'(addr));
            push_str("00");
            sum = 8'(n) + 8'(addr >> 8) + 8'(addr);
            for (int i = 0; i < n; i++) begin
                b = romb(addr + i);
                push_hex(b);
                sum = sum + b;
            end
            push_hex(8'h00 - sum);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            addr += n;
        end
        push_str(":00000001FF");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic string get_str(input int pos, input int len);
        string r = "";
        for (int i = 0; i < len; i++)
            if (pos + i < rx_q.size()) r = $sformatf("%s%c", r, rx_q[pos + i]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            pend      = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (pend) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pend_d);
            end
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_char: got %0h expected no character", tx_data);
                end else begin
                    check("char", tx_data, exp_q.pop_front());
                end
            end
            pend   = tx_valid && !tx_ready;
            pend_d = tx_data;
            if (done) begin
                check("busy_at_done", busy, 0);
                check("done_width", done_prev, 0);
                done_cnt++;
            end
            done_prev = done;
            if (addr_watch && rom_addr != addr_ref) addr_moved = 1'b1;
        end
    end

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start  = 1'b1;
        length = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        check("first_colon_valid", tx_valid, 1);
        check("first_colon_data", tx_data, 8'h3A);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int i = 0;
        while (rx_q.size() < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("rx_progress", rx_q.size() >= n, 1);
    endtask

    task automatic finish_case(input int d0, input int budget);
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("done_seen", done_cnt != d0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("leftover", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_case(input int len, input int budget);
        int d0 = done_cnt;
        do_start(len);
        finish_case(d0, budget);
    endtask

    initial begin
        int colons, d0;
        reset  = 1'b1;
        start  = 1'b0;
        length = 16'h0;
        for (int w = 0; w < 16384; w++) rom[w] = {romb(2 * w + 1), romb(2 * w)};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;

        // Three bytes, hand-computed stream
        rx_q.delete();
        push_str(":030000000C943429");
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        push_str(":00000001FF");
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        run_case(3, 500);
        check_str("stream3", get_str(0, rx_q.size()),
                  {":030000000C943429", "\r\n", ":00000001FF", "\r\n"});

        // Zero length: EOF only, ROM address untouched
        rx_q.delete();
        addr_ref   = rom_addr;
        addr_moved = 1'b0;
        addr_watch = 1'b1;
        push_str(":00000001FF");
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        run_case(0, 200);
        addr_watch = 1'b0;
        check("rom_addr_still", addr_moved, 0);
        check("len0_chars", rx_q.size(), 13);

        // Two records
        rx_q.delete();
        model_dump(20);
        run_case(20, 2000);
        check_str("hdr_rec0", get_str(0, 9), ":10000000");
        check_str("hdr_rec1", get_str(45, 9), ":04001000");
        check("len20_chars", rx_q.size(), 79);
        ref20 = get_str(0, rx_q.size());

        // Back-pressure
        rx_q.delete();
        ready_mode = 2;
        model_dump(20);
        run_case(20, 5000);
        ready_mode = 1;
        check_str("rand_stream", get_str(0, rx_q.size()), ref20);

        // start while busy is ignored
        rx_q.delete();
        model_dump(20);
        d0 = done_cnt;
        do_start(20);
        wait_rx(20, 500);
        @(posedge clk); #1;
        start  = 1'b1;
        length = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        finish_case(d0, 2000);
        check_str("restart_ignored", get_str(0, rx_q.size()), ref20);

        // Reset mid-data, then a fresh dump
        rx_q.delete();
        model_dump(20);
        do_start(20);
        wait_rx(12, 500);
        @(posedge clk); #1;
        ready_mode = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_mid_valid", tx_valid, 0);
        check("rst_mid_busy", busy, 0);
        reset      = 1'b0;
        ready_mode = 1;
        rx_q.delete();
        model_dump(20);
        run_case(20, 2000);
        check_str("after_reset", get_str(0, rx_q.size()), ref20);

        // Length above the ROM window is clamped
        rx_q.delete();
        model_dump(40000);
        run_case(40000, 20000);
        colons = 0;
        foreach (rx_q[i]) if (rx_q[i] == 8'h3A) colons++;
        check("clamp_records", colons, DUMP / 16 + 1);
        check_str("clamp_last_hdr", get_str((DUMP / 16 - 1) * 45, 9), ":1007F000");
        check("clamp_chars", rx_q.size(), (DUMP / 16) * 45 + 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
